// File: rtl/hash_load_controller_pkg.sv
// Command codes, hash geometry and FSM state type shared by the hash loader blocks.
package hash_cmd_pkg;

    localparam logic [7:0] CMD_START = 8'hAA;
    localparam logic [7:0] CMD_NEXT  = 8'h88;
    localparam logic [7:0] CMD_STOP  = 8'hEE;
    localparam logic [7:0] CMD_PROG  = 8'h6C;

    localparam int HASH_BYTES = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        SEP,
        DONE
    } hash_state_t;

endpackage

// File: rtl/hash_load_controller_if.sv
// Single-port SRAM bus: the controller is master, the SRAM wrapper is slave.
interface hash_sram_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 128
);
    logic              read_enable;
    logic              write_enable;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] read_data;

    modport master (
        output read_enable,
        output write_enable,
        output address,
        output write_data,
        input  read_data
    );

    modport slave (
        input  read_enable,
        input  write_enable,
        input  address,
        input  write_data,
        output read_data
    );
endinterface

// File: rtl/hash_load_controller_byte_assembler.sv
// Packs received bytes MSB-first into one hash word; o_last marks the byte that completes it.
module hash_byte_assembler
    import hash_cmd_pkg::*;
#(
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_shift,
    input  logic [7:0]        i_byte,
    output logic [DATA_W-1:0] o_word,
    output logic              o_last,
    output logic              o_full
);
    logic [DATA_W-1:0] r_word;
    logic [3:0]        r_count;
    logic              r_full;

    assign o_last = i_shift && (r_count == 4'(HASH_BYTES - 1));
    assign o_word = r_word;
    assign o_full = r_full;

    // The counter wraps to 0 on the completing byte, so a fresh word needs no explicit clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else if (i_clear) begin
            r_word  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
        end else if (i_shift) begin
            r_word  <= {r_word[DATA_W-9:0], i_byte};
            r_count <= r_count + 4'd1;
            if (o_last) begin
                r_full <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/hash_load_controller.sv
// UART command parser that loads 128-bit NTLM target hashes into SRAM, then
// lends the single SRAM port to the cracker core for one read at a time.
module hash_load_controller
    import hash_cmd_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 128,
    parameter int MAX_HASHES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    input  logic              i_rx_error,
    input  logic              i_crk_req,
    input  logic [ADDR_W-1:0] i_crk_addr,
    output logic              o_crk_gnt,
    output logic              o_crk_rdata_valid,
    output logic [DATA_W-1:0] o_crk_rdata,
    hash_sram_if.master       sram,
    output logic [ADDR_W:0]   o_hash_count,
    output logic              o_load_done,
    output logic              o_prog_req,
    output logic              o_err
);
    localparam logic [ADDR_W:0] MAX_COUNT = (ADDR_W + 1)'(MAX_HASHES);
    localparam logic [ADDR_W:0] ONE_HASH  = (ADDR_W + 1)'(1);

    hash_state_t       r_state;
    logic [ADDR_W:0]   r_hashCount;
    logic              r_loadDone;
    logic              r_progReq;
    logic              r_err;
    logic              r_rdataValid;

    logic              w_startCmd;
    logic              w_abort;
    logic              w_shift;
    logic              w_clear;
    logic              w_last;
    logic              w_full;
    logic              w_write;
    logic              w_gnt;
    logic [DATA_W-1:0] w_word;

    assign w_startCmd = i_rx_valid && (i_rx_data == CMD_START) &&
                        ((r_state == IDLE) || (r_state == DONE));
    assign w_abort    = i_rx_error && ((r_state == LOAD) || (r_state == SEP));
    assign w_shift    = (r_state == LOAD) && i_rx_valid && !i_rx_error;
    assign w_clear    = w_startCmd || w_abort || (r_state == WRITE);

    hash_byte_assembler #(
        .DATA_W (DATA_W)
    ) u_assembler (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_clear),
        .i_shift (w_shift),
        .i_byte  (i_rx_data),
        .o_word  (w_word),
        .o_last  (w_last),
        .o_full  (w_full)
    );

    // Grants only happen while load_done is high, so they can never collide with a loader write.
    assign w_write = (r_state == WRITE) && w_full;
    assign w_gnt   = i_crk_req && r_loadDone && ({1'b0, i_crk_addr} < r_hashCount);

    assign sram.write_enable = w_write;
    assign sram.read_enable  = w_gnt;
    assign sram.address      = w_write ? r_hashCount[ADDR_W-1:0] :
                               (w_gnt ? i_crk_addr : '0);
    assign sram.write_data   = w_write ? w_word : '0;

    assign o_crk_gnt         = w_gnt;
    assign o_crk_rdata_valid = r_rdataValid;
    assign o_crk_rdata       = r_rdataValid ? sram.read_data : '0;
    assign o_hash_count      = r_hashCount;
    assign o_load_done       = r_loadDone;
    assign o_prog_req        = r_progReq;
    assign o_err             = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_hashCount  <= '0;
            r_loadDone   <= 1'b0;
            r_progReq    <= 1'b0;
            r_err        <= 1'b0;
            r_rdataValid <= 1'b0;
        end else begin
            r_progReq    <= 1'b0;
            r_rdataValid <= w_gnt;
            case (r_state)
                IDLE, DONE: begin
                    if (i_rx_valid) begin
                        if (i_rx_data == CMD_START) begin
                            r_hashCount <= '0;
                            r_err       <= 1'b0;
                            r_loadDone  <= 1'b0;
                            r_state     <= LOAD;
                        end else if (i_rx_data == CMD_PROG) begin
                            r_progReq <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (i_rx_error) begin
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                    end else if (w_last) begin
                        r_state <= WRITE;
                    end
                end
                WRITE: begin
                    r_hashCount <= r_hashCount + ONE_HASH;
                    if (i_rx_valid) begin
                        r_err <= 1'b1;
                    end
                    r_state <= SEP;
                end
                SEP: begin
                    if (i_rx_error) begin
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                    end else if (i_rx_valid) begin
                        if ((i_rx_data == CMD_NEXT) && (r_hashCount != MAX_COUNT)) begin
                            r_state <= LOAD;
                        end else begin
                            // Either a clean stop, a full table, or a bad separator: all end the load.
                            if (i_rx_data != CMD_STOP) begin
                                r_err <= 1'b1;
                            end
                            r_loadDone <= 1'b1;
                            r_state    <= DONE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hash_load_controller.sv
// Scoreboard bench for hash_load_controller: session-level reference model, SRAM model, decoupled monitors.
module tb_hash_load_controller;
    import hash_cmd_pkg::*;

    localparam int ADDR_W     = 10;
    localparam int DATA_W     = 128;
    localparam int MAX_HASHES = 2;

    localparam logic [127:0] HASH1 = 128'hE2E35A421944255FEB8EF91A141AC2D5;
    localparam logic [127:0] HASH2 = 128'h16958FECA9930E98CCD4E9376735A43A;
    localparam logic [127:0] HASH_PROG3 = 128'h11226C445566778899AABBCCDDEEFF01;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        rxData = '0;
    logic              rxValid = 1'b0;
    logic              rxError = 1'b0;
    logic              crkReq = 1'b0;
    logic [ADDR_W-1:0] crkAddr = '0;
    logic              crkGnt;
    logic              crkRdataValid;
    logic [DATA_W-1:0] crkRdata;
    logic [ADDR_W:0]   hashCount;
    logic              loadDone;
    logic              progReq;
    logic              err;

    hash_sram_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) sramBus ();

    hash_load_controller #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MAX_HASHES (MAX_HASHES)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .i_rx_data         (rxData),
        .i_rx_valid        (rxValid),
        .i_rx_error        (rxError),
        .i_crk_req         (crkReq),
        .i_crk_addr        (crkAddr),
        .o_crk_gnt         (crkGnt),
        .o_crk_rdata_valid (crkRdataValid),
        .o_crk_rdata       (crkRdata),
        .sram              (sramBus),
        .o_hash_count      (hashCount),
        .o_load_done       (loadDone),
        .o_prog_req        (progReq),
        .o_err             (err)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] sramMem [0:(1<<ADDR_W)-1];

    always @(posedge clk) begin
        if (sramBus.write_enable) sramMem[sramBus.address] <= sramBus.write_data;
        if (sramBus.read_enable) sramBus.read_data <= sramMem[sramBus.address];
    end

    wr_t               writeQ[$];
    logic [DATA_W-1:0] readQ[$];
    int                progQ[$];
    logic [DATA_W-1:0] expMem [int];
    logic [DATA_W-1:0] sessWords[$];
    int                expCount = 0;
    bit                expDone = 1'b0;
    bit                expErr = 1'b0;
    int                tests = 0;
    int                fails = 0;
    wr_t               monWr;
    logic [DATA_W-1:0] monRd;
    int                monProg;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every SRAM write, read return and progress pulse must match the next expected entry.
    always @(negedge clk) begin
        if (!rst) begin
            if (sramBus.write_enable) begin
                if (writeQ.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_write: got addr %0d data %h expected no write",
                             sramBus.address, sramBus.write_data);
                end else begin
                    monWr = writeQ.pop_front();
                    checkOutput("write_addr", 128'(sramBus.address), 128'(monWr.addr));
                    checkOutput("write_data", sramBus.write_data, monWr.data);
                end
                checkOutput("enables_exclusive", 128'(sramBus.read_enable), 128'(0));
            end
            if (crkRdataValid) begin
                if (readQ.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_rdata: got %h expected no read return", crkRdata);
                end else begin
                    monRd = readQ.pop_front();
                    checkOutput("crk_rdata", crkRdata, monRd);
                end
            end
            if (progReq) begin
                if (progQ.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_prog_req: got 1 expected 0");
                end else begin
                    monProg = progQ.pop_front();
                    checkOutput("prog_req", 128'(progReq), 128'(monProg));
                end
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] b);
        @(posedge clk); #1;
        rxData  = b;
        rxValid = 1'b1;
        @(posedge clk); #1;
        rxValid = 1'b0;
    endtask

    task automatic applyBackToBack(input logic [7:0] b0, input logic [7:0] b1);
        @(posedge clk); #1;
        rxData  = b0;
        rxValid = 1'b1;
        @(posedge clk); #1;
        rxData  = b1;
        @(posedge clk); #1;
        rxValid = 1'b0;
    endtask

    task automatic pulseRxError();
        @(posedge clk); #1;
        rxError = 1'b1;
        @(posedge clk); #1;
        rxError = 1'b0;
    endtask

    function automatic logic [7:0] dataByte();
        case ($urandom_range(0, 7))
            0:       return CMD_START;
            1:       return CMD_PROG;
            2:       return CMD_NEXT;
            3:       return CMD_STOP;
            default: return 8'($urandom);
        endcase
    endfunction

    function automatic logic [127:0] randomWord();
        logic [127:0] w;
        for (int i = 0; i < HASH_BYTES; i++) w[127-8*i -: 8] = dataByte();
        return w;
    endfunction

    // term: 0 clean stop, 1 bad separator, 2 NEXT on full table, 3 stray byte during the write cycle.
    // abortHash: index of hash during which rx_error hits (== word count means at the separator), -1 none.
    task automatic loadSession(input int term, input int abortHash, input int abortBytes);
        logic [127:0] w;
        logic [7:0]   bad;
        applyStimulus(CMD_START);
        expCount = 0;
        expErr   = 1'b0;
        expDone  = 1'b0;
        for (int h = 0; h < sessWords.size(); h++) begin
            w = sessWords[h];
            if (h > 0) applyStimulus(CMD_NEXT);
            if (h == abortHash) begin
                for (int i = 0; i < abortBytes; i++) applyStimulus(w[127-8*i -: 8]);
                pulseRxError();
                expErr = 1'b1;
                return;
            end
            writeQ.push_back('{addr: ADDR_W'(h), data: w});
            expMem[h] = w;
            for (int i = 0; i < HASH_BYTES - 1; i++) applyStimulus(w[127-8*i -: 8]);
            if (term == 3 && h == sessWords.size() - 1) begin
                applyBackToBack(w[7:0], dataByte());
                expErr = 1'b1;
            end else begin
                applyStimulus(w[7:0]);
            end
            expCount = h + 1;
        end
        if (abortHash == sessWords.size()) begin
            pulseRxError();
            expErr = 1'b1;
            return;
        end
        case (term)
            1: begin
                bad = dataByte();
                while (bad == CMD_NEXT || bad == CMD_STOP) bad = 8'($urandom);
                applyStimulus(bad);
                expErr = 1'b1;
            end
            2: begin
                applyStimulus(CMD_NEXT);
                expErr = 1'b1;
            end
            default: applyStimulus(CMD_STOP);
        endcase
        expDone = 1'b1;
    endtask

    task automatic doRead(input int a);
        bit expGnt;
        expGnt = expDone && (a < expCount);
        @(posedge clk); #1;
        crkReq  = 1'b1;
        crkAddr = ADDR_W'(a);
        @(negedge clk);
        checkOutput("crk_gnt", 128'(crkGnt), 128'(expGnt));
        checkOutput("read_enable", 128'(sramBus.read_enable), 128'(expGnt));
        if (expGnt) begin
            checkOutput("read_address", 128'(sramBus.address), 128'(a));
            readQ.push_back(expMem[a]);
        end
        @(posedge clk); #1;
        crkReq = 1'b0;
    endtask

    // Traffic legal outside a load: ignored bytes, progress requests and ignored rx_error strobes.
    task automatic idleNoise(input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 3))
                0: pulseRxError();
                1: begin
                    progQ.push_back(1);
                    applyStimulus(CMD_PROG);
                end
                default: begin
                    b = dataByte();
                    if (b == CMD_START) b = 8'h00;
                    if (b == CMD_PROG) progQ.push_back(1);
                    applyStimulus(b);
                end
            endcase
        end
    endtask

    task automatic checkStatus(input string tag);
        @(negedge clk);
        @(negedge clk);
        checkOutput({tag, "_hash_count"}, 128'(hashCount), 128'(expCount));
        checkOutput({tag, "_load_done"}, 128'(loadDone), 128'(expDone));
        checkOutput({tag, "_err"}, 128'(err), 128'(expErr));
        checkOutput({tag, "_pending_writes"}, 128'(writeQ.size()), 128'(0));
        checkOutput({tag, "_pending_reads"}, 128'(readQ.size()), 128'(0));
        checkOutput({tag, "_pending_prog"}, 128'(progQ.size()), 128'(0));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_crk_gnt"}, 128'(crkGnt), 128'(0));
        checkOutput({tag, "_crk_rdata_valid"}, 128'(crkRdataValid), 128'(0));
        checkOutput({tag, "_crk_rdata"}, crkRdata, 128'(0));
        checkOutput({tag, "_read_enable"}, 128'(sramBus.read_enable), 128'(0));
        checkOutput({tag, "_write_enable"}, 128'(sramBus.write_enable), 128'(0));
        checkOutput({tag, "_address"}, 128'(sramBus.address), 128'(0));
        checkOutput({tag, "_write_data"}, sramBus.write_data, 128'(0));
        checkOutput({tag, "_hash_count"}, 128'(hashCount), 128'(0));
        checkOutput({tag, "_load_done"}, 128'(loadDone), 128'(0));
        checkOutput({tag, "_prog_req"}, 128'(progReq), 128'(0));
        checkOutput({tag, "_err"}, 128'(err), 128'(0));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected $finish");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

    initial begin
        int nHash, term, abortHash, abortBytes;
        logic [127:0] w;

        crkReq = 1'b1;
        repeat (2) @(negedge clk);
        checkAllZero("reset");
        @(posedge clk); #1;
        crkReq = 1'b0;
        rst    = 1'b0;

        sessWords = '{HASH1};
        loadSession(0, -1, 0);
        checkStatus("single");

        sessWords = '{HASH1, HASH2};
        loadSession(0, -1, 0);
        checkStatus("two");
        doRead(1);
        doRead(2);
        doRead(0);
        checkStatus("reads");

        progQ.push_back(1);
        applyStimulus(CMD_PROG);
        checkStatus("prog_done");

        sessWords = '{HASH_PROG3};
        loadSession(0, -1, 0);
        checkStatus("prog_as_data");

        sessWords = '{HASH1};
        loadSession(0, 0, 5);
        checkStatus("rx_error_load");
        doRead(0);
        progQ.push_back(1);
        applyStimulus(CMD_PROG);
        checkStatus("idle_after_error");

        applyStimulus(CMD_START);
        w = HASH2;
        for (int i = 0; i < 7; i++) applyStimulus(w[127-8*i -: 8]);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        checkAllZero("mid_load_reset");
        expCount = 0;
        expDone  = 1'b0;
        expErr   = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        sessWords = '{HASH1};
        loadSession(0, -1, 0);
        checkStatus("after_reset");
        doRead(0);

        sessWords = '{HASH1, HASH2};
        loadSession(2, -1, 0);
        checkStatus("overflow");
        doRead(1);

        sessWords = '{HASH2};
        loadSession(3, -1, 0);
        checkStatus("byte_in_write");

        sessWords = '{HASH1};
        loadSession(0, 1, 0);
        checkStatus("rx_error_sep");

        for (int it = 0; it < 25; it++) begin
            nHash = $urandom_range(1, MAX_HASHES);
            term  = $urandom_range(0, 3);
            if (term == 2 && nHash < MAX_HASHES) term = 0;
            abortHash  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nHash) : -1;
            abortBytes = $urandom_range(0, HASH_BYTES - 1);
            sessWords.delete();
            for (int h = 0; h < nHash; h++) sessWords.push_back(randomWord());
            idleNoise($urandom_range(0, 3));
            loadSession(term, abortHash, abortBytes);
            checkStatus("random");
            for (int r = 0; r < 3; r++) doRead($urandom_range(0, 3));
            idleNoise($urandom_range(0, 4));
            checkStatus("random_tail");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
